// File: rtl/demux_rr_sched.sv
// rtl/demux_rr_sched.sv - round-robin burst scheduler driving a 1-to-16 demux select/enable
module demux_rr_sched #(
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        req,
  input  logic [BURST_W-1:0] burst_len,
  output logic [3:0]         sel,
  output logic               demux_en,
  output logic [15:0]        grant,
  output logic               busy,
  output logic               grant_end
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t             state, state_nxt;
  logic [3:0]         ptr, ptr_nxt;
  logic [3:0]         sel_nxt;
  logic [BURST_W-1:0] cnt, cnt_nxt;
  logic               en_nxt, gend_nxt;
  logic [15:0]        grant_nxt;
  logic [3:0]         winner, scan_idx;
  logic               found;

  // Rotating priority search starting at ptr, wrapping 15 -> 0.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int i = 0; i < 16; i++) begin
      scan_idx = ptr + 4'(i);
      if (!found && req[scan_idx]) begin
        winner = scan_idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    en_nxt    = demux_en;
    grant_nxt = grant;
    gend_nxt  = 1'b0;
    case (state)
      IDLE, GAP: begin
        en_nxt    = 1'b0;
        grant_nxt = '0;
        state_nxt = IDLE;
        if (found) begin
          state_nxt = GRANT;
          sel_nxt   = winner;
          grant_nxt = 16'd1 << winner;
          en_nxt    = 1'b1;
          cnt_nxt   = (burst_len == '0) ? BURST_W'(1) : burst_len;
          ptr_nxt   = winner + 4'd1;
        end
      end
      GRANT: begin
        cnt_nxt = cnt - BURST_W'(1);
        if (cnt == BURST_W'(1) || !req[sel]) begin
          state_nxt = GAP;
          en_nxt    = 1'b0;
          grant_nxt = '0;
          gend_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        en_nxt    = 1'b0;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= '0;
      ptr       <= '0;
      cnt       <= '0;
      demux_en  <= 1'b0;
      grant     <= '0;
      grant_end <= 1'b0;
    end else begin
      state     <= state_nxt;
      sel       <= sel_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
      demux_en  <= en_nxt;
      grant     <= grant_nxt;
      grant_end <= gend_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_demux_rr_sched.sv
// tb/tb_demux_rr_sched.sv - directed self-checking bench for demux_rr_sched
module tb_demux_rr_sched;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic [3:0]  burst_len;
  logic [3:0]  sel;
  logic        demux_en;
  logic [15:0] grant;
  logic        busy;
  logic        grant_end;

  // Observed vector: {sel, demux_en, grant, busy, grant_end}
  logic [22:0] obs;
  logic [22:0] exp_v;
  int          checks;
  int          errors;

  demux_rr_sched #(.BURST_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .burst_len (burst_len),
    .sel       (sel),
    .demux_en  (demux_en),
    .grant     (grant),
    .busy      (busy),
    .grant_end (grant_end)
  );

  assign obs = {sel, demux_en, grant, busy, grant_end};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req       = '0;
    burst_len = 4'd1;
    rst_n     = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req       = '0;
    burst_len = 4'd1;
    rst_n     = 1'b0;
    #2;
    checks++;
    exp_v = {4'd0, 1'b0, 16'h0000, 1'b0, 1'b0};
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_hold obs=%h exp=%h", obs, exp_v);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_idle[%0d] obs=%h exp=%h", i, obs, exp_v);
      end
    end
    req = 16'h0001;
    tick();
    checks++;
    exp_v = {4'd0, 1'b1, 16'h0001, 1'b1, 1'b0};
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_pre_grant obs=%h exp=%h", obs, exp_v);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    exp_v = {4'd0, 1'b0, 16'h0000, 1'b0, 1'b0};
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_async obs=%h exp=%h", obs, exp_v);
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_single_burst();
    do_reset();
    req       = 16'h0020;
    burst_len = 4'd3;
    tick();
    burst_len = 4'd15;
    for (int i = 0; i < 3; i++) begin
      checks++;
      exp_v = {4'd5, 1'b1, 16'h0020, 1'b1, 1'b0};
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL burst_cycle[%0d] obs=%h exp=%h", i, obs, exp_v);
      end
      tick();
    end
    checks++;
    exp_v = {4'd5, 1'b0, 16'h0000, 1'b1, 1'b1};
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL burst_gap obs=%h exp=%h", obs, exp_v);
    end
    tick();
    checks++;
    exp_v = {4'd5, 1'b1, 16'h0020, 1'b1, 1'b0};
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL burst_regrant obs=%h exp=%h", obs, exp_v);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] ch;
    do_reset();
    req       = 16'hFFFF;
    burst_len = 4'd1;
    tick();
    for (int i = 0; i < 17; i++) begin
      ch = 4'(i);
      checks++;
      exp_v = {ch, 1'b1, 16'd1 << ch, 1'b1, 1'b0};
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL rr_grant[%0d] obs=%h exp=%h", i, obs, exp_v);
      end
      tick();
      checks++;
      exp_v = {ch, 1'b0, 16'h0000, 1'b1, 1'b1};
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL rr_gap[%0d] obs=%h exp=%h", i, obs, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_wrap_priority();
    do_reset();
    req       = 16'h8000;
    burst_len = 4'd1;
    tick();
    checks++;
    exp_v = {4'd15, 1'b1, 16'h8000, 1'b1, 1'b0};
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL wrap_first obs=%h exp=%h", obs, exp_v);
    end
    req = 16'h4001;
    tick();
    tick();
    checks++;
    exp_v = {4'd0, 1'b1, 16'h0001, 1'b1, 1'b0};
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL wrap_ch0 obs=%h exp=%h", obs, exp_v);
    end
    tick();
    tick();
    checks++;
    exp_v = {4'd14, 1'b1, 16'h4000, 1'b1, 1'b0};
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL wrap_ch14 obs=%h exp=%h", obs, exp_v);
    end
  endtask

  task automatic test_early_release();
    do_reset();
    req       = 16'h0100;
    burst_len = 4'd10;
    tick();
    tick();
    checks++;
    exp_v = {4'd8, 1'b1, 16'h0100, 1'b1, 1'b0};
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL early_grant obs=%h exp=%h", obs, exp_v);
    end
    req = 16'h0000;
    tick();
    checks++;
    exp_v = {4'd8, 1'b0, 16'h0000, 1'b1, 1'b1};
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL early_gap obs=%h exp=%h", obs, exp_v);
    end
    tick();
    checks++;
    exp_v = {4'd8, 1'b0, 16'h0000, 1'b0, 1'b0};
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL early_idle obs=%h exp=%h", obs, exp_v);
    end
  endtask

  task automatic test_burst_zero();
    do_reset();
    req       = 16'h0004;
    burst_len = 4'd0;
    tick();
    checks++;
    exp_v = {4'd2, 1'b1, 16'h0004, 1'b1, 1'b0};
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL bl0_grant obs=%h exp=%h", obs, exp_v);
    end
    tick();
    checks++;
    exp_v = {4'd2, 1'b0, 16'h0000, 1'b1, 1'b1};
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL bl0_gap obs=%h exp=%h", obs, exp_v);
    end
  endtask

  task automatic test_mid_grant_reset();
    do_reset();
    req       = 16'h0010;
    burst_len = 4'd5;
    tick();
    tick();
    checks++;
    exp_v = {4'd4, 1'b1, 16'h0010, 1'b1, 1'b0};
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL midrst_grant obs=%h exp=%h", obs, exp_v);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    exp_v = {4'd0, 1'b0, 16'h0000, 1'b0, 1'b0};
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL midrst_clear obs=%h exp=%h", obs, exp_v);
    end
    #2 rst_n = 1'b1;
    req = 16'h0011;
    tick();
    checks++;
    exp_v = {4'd0, 1'b1, 16'h0001, 1'b1, 1'b0};
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL midrst_ptr obs=%h exp=%h", obs, exp_v);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    req       = '0;
    burst_len = 4'd1;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_wrap_priority();
    test_early_release();
    test_burst_zero();
    test_mid_grant_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
